// File: rtl/hack_mem_io.sv
// rtl/hack_mem_io.sv - Hack data RAM plus LED, switch, button-edge and millisecond-timer I/O
// Optional button debouncer enabled by HACK_MEM_IO_DEBOUNCE_EN.
module hack_mem_io #(
    parameter int DW         = 16,
    parameter int AW         = 15,
    parameter int RAM_DEPTH  = 16384,
    parameter int SW_W       = 8,
    parameter int BTN_W      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          en25m,
    input  logic          writeM,
    input  logic [DW-1:0] outM,
    input  logic [AW-1:0] addressM,
    output logic [DW-1:0] inM,
    output logic [DW-1:0] led,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn
);

    localparam int RW = $clog2(RAM_DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [AW-1:0] RAM_TOP = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0] A_LED   = AW'('h6000);
    localparam logic [AW-1:0] A_SW    = AW'('h6001);
    localparam logic [AW-1:0] A_BTN   = AW'('h6002);
    localparam logic [AW-1:0] A_TIMER = AW'('h6003);

    logic            wr_commit;
    logic            is_ram;
    logic            ram_we;
    logic [RW-1:0]   ram_idx;
    logic [DW-1:0]   ram [RAM_DEPTH];
    logic [DW-1:0]   ram_rdata_q;

    logic [DW-1:0]    led_q, led_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [BTN_W-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
    logic [BTN_W-1:0] btn_edge_q, btn_edge_d;
    logic [BTN_W-1:0] btn_lvl;
    logic [BTN_W-1:0] btn_rise;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    timer_q, timer_d;
    logic             tick;
    logic [DW-1:0]    reg_rd_q, reg_rd_d;
    logic             rd_ram_q, rd_ram_d;

    assign wr_commit = en25m & writeM;
    assign is_ram    = (addressM <= RAM_TOP);
    assign ram_we    = wr_commit & is_ram;
    assign ram_idx   = addressM[RW-1:0];

    // Old contents are returned when reading and writing the same word on one edge.
    always_ff @(posedge clk50m) begin
        if (ram_we) begin
            ram[ram_idx] <= outM;
        end
        ram_rdata_q <= ram[ram_idx];
    end

`ifdef HACK_MEM_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [BTN_W-1:0] deb_q, deb_d;
    logic [CW-1:0]    deb_cnt_q [BTN_W];
    logic [CW-1:0]    deb_cnt_d [BTN_W];

    // Counter tracks consecutive cycles the input disagrees with the debounced level.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < BTN_W; i++) begin
            deb_cnt_d[i] = '0;
            if (btn_s2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = btn_s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < BTN_W; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < BTN_W; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign btn_lvl = deb_q;
`else
    logic unused_deb_cycles;
    assign unused_deb_cycles = ^DEB_CYCLES;
    assign btn_lvl = btn_s2_q;
`endif

    assign btn_rise = btn_lvl & ~btn_prev_q;
    assign tick     = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        led_d      = led_q;
        sw_s1_d    = sw;
        sw_s2_d    = sw_s1_q;
        btn_s1_d   = btn;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_lvl;
        btn_edge_d = btn_edge_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        timer_d    = tick ? timer_q + DW'(1) : timer_q;

        if (wr_commit) begin
            case (addressM)
                A_LED:   led_d = outM;
                A_BTN:   btn_edge_d = btn_edge_q & ~outM[BTN_W-1:0];
                A_TIMER: begin
                    timer_d = outM;
                    presc_d = '0;
                end
                default: ;
            endcase
        end
        // Applied after the clear so a coincident edge keeps its bit.
        btn_edge_d = btn_edge_d | btn_rise;

        rd_ram_d = is_ram;
        reg_rd_d = '0;
        case (addressM)
            A_LED:   reg_rd_d = led_q;
            A_SW:    reg_rd_d = DW'(sw_s2_q);
            A_BTN:   reg_rd_d = DW'(btn_edge_q);
            A_TIMER: reg_rd_d = timer_q;
            default: reg_rd_d = '0;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            presc_q    <= '0;
            timer_q    <= '0;
            reg_rd_q   <= '0;
            rd_ram_q   <= 1'b0;
        end else begin
            led_q      <= led_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
            btn_edge_q <= btn_edge_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            reg_rd_q   <= reg_rd_d;
            rd_ram_q   <= rd_ram_d;
        end
    end

    // rd_ram_q resets low, so inM reads zero during reset even though RAM output is not reset.
    assign inM = rd_ram_q ? ram_rdata_q : reg_rd_q;
    assign led = led_q;

endmodule

// File: tb/tb_hack_mem_io.sv
// tb/tb_hack_mem_io.sv - self-checking bench for hack_mem_io against a behavioural memory-map model
module tb_hack_mem_io;

    localparam int TD = 4;
    localparam int RD = 16384;

    logic        clk50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        en25m = 1'b0;
    logic        writeM = 1'b0;
    logic [15:0] outM = '0;
    logic [14:0] addressM = '0;
    logic [15:0] inM;
    logic [15:0] led;
    logic [7:0]  sw = '0;
    logic [3:0]  btn = '0;

    hack_mem_io #(.TICK_DIV(TD), .DEB_CYCLES(8)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .en25m(en25m), .writeM(writeM),
        .outM(outM), .addressM(addressM), .inM(inM), .led(led),
        .sw(sw), .btn(btn)
    );

    always #10 clk50m = ~clk50m;

    int n_checks = 0;
    int n_pass = 0;

    logic [15:0] ram_m [int];
    logic [15:0] led_m;
    logic [3:0]  edge_m;
    logic [15:0] tval;
    int          tcyc;
    int          cyc;
    logic [3:0]  bh [3];
    logic [7:0]  swh [2];
    logic [14:0] ram_set [8];

    function automatic logic [15:0] mread(input logic [14:0] a);
        if (int'(a) < RD) return ram_m[int'(a)];
        case (a)
            15'h6000: return led_m;
            15'h6001: return {8'h00, swh[1]};
            15'h6002: return {12'h000, edge_m};
            15'h6003: return tval + 16'((cyc - tcyc) / TD);
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        led_m = '0; edge_m = '0; tval = '0; tcyc = 0; cyc = 0;
        for (int i = 0; i < 3; i++) bh[i] = '0;
        for (int i = 0; i < 2; i++) swh[i] = '0;
    endtask

    task automatic model_edge(input logic we, input logic en, input logic [14:0] a, input logic [15:0] d);
        logic [3:0] rise;
        logic [3:0] clr;
`ifdef HACK_MEM_IO_DEBOUNCE_EN
        rise = '0;
`else
        rise = bh[1] & ~bh[2];
`endif
        clr = '0;
        cyc++;
        if (we && en) begin
            if (int'(a) < RD) ram_m[int'(a)] = d;
            else if (a == 15'h6000) led_m = d;
            else if (a == 15'h6002) clr = d[3:0];
            else if (a == 15'h6003) begin
                tval = d;
                tcyc = cyc;
            end
        end
        edge_m = (edge_m & ~clr) | rise;
        bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = btn;
        swh[1] = swh[0]; swh[0] = sw;
    endtask

    task automatic step(input logic we, input logic en, input logic [14:0] a, input logic [15:0] d,
                        output logic [15:0] got, output logic [15:0] exp);
        writeM = we; en25m = en; addressM = a; outM = d;
        exp = mread(a);
        @(posedge clk50m);
        model_edge(we, en, a, d);
        #1;
        got = inM;
        writeM = 1'b0;
        en25m = ~en25m;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk50m);
        @(posedge clk50m);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] g, e;
        logic [14:0] regs [3];
        regs[0] = 15'h6000; regs[1] = 15'h6002; regs[2] = 15'h6003;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, regs[i], 16'h0, g, e);
            n_checks++;
            if (g !== 16'h0000) $display("FAIL reset_read[%0h] got=%h exp=0000", regs[i], g);
            else n_pass++;
        end
        n_checks++;
        if (led !== 16'h0000) $display("FAIL reset_led got=%h exp=0000", led);
        else n_pass++;
    endtask

    task automatic test_ram();
        logic [15:0] g, e;
        logic [14:0] a;
        step(1'b1, 1'b1, 15'h0005, 16'h1234, g, e);
        step(1'b0, 1'b0, 15'h0005, 16'h0, g, e);
        step(1'b0, 1'b1, 15'h0005, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h1234) $display("FAIL ram_write got=%h exp=1234", g);
        else n_pass++;
        step(1'b1, 1'b0, 15'h0005, 16'hFFFF, g, e);
        step(1'b0, 1'b1, 15'h0005, 16'h0, g, e);
        step(1'b0, 1'b0, 15'h0005, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h1234) $display("FAIL ram_no_en got=%h exp=1234", g);
        else n_pass++;
        ram_set[0] = 15'h0000; ram_set[1] = 15'h3FFF; ram_set[2] = 15'h0005; ram_set[3] = 15'h0100;
        ram_set[4] = 15'h2AAA; ram_set[5] = 15'h1555; ram_set[6] = 15'h3FFE; ram_set[7] = 15'h0001;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, ram_set[i], 16'($urandom), g, e);
        for (int i = 0; i < 40; i++) begin
            a = ram_set[$urandom_range(0, 7)];
            step(1'($urandom), 1'($urandom), a, 16'($urandom), g, e);
            step(1'b0, 1'b0, a, 16'h0, g, e);
            step(1'b0, 1'b1, a, 16'h0, g, e);
            n_checks++;
            if (g !== e) $display("FAIL ram_random[%0h] got=%h exp=%h", a, g, e);
            else n_pass++;
        end
        a = ram_set[3];
        step(1'b0, 1'b0, a, 16'h0, g, e);
        step(1'b1, 1'b1, a, 16'hBEEF, g, e);
        n_checks++;
        if (g !== e) $display("FAIL ram_read_before_write got=%h exp=%h", g, e);
        else n_pass++;
    endtask

    task automatic test_led_unmapped();
        logic [15:0] g, e;
        step(1'b1, 1'b1, 15'h6000, 16'hA5A5, g, e);
        n_checks++;
        if (led !== 16'hA5A5) $display("FAIL led_write got=%h exp=a5a5", led);
        else n_pass++;
        step(1'b1, 1'b1, 15'h6000, 16'h5A5A, g, e);
        n_checks++;
        if (g !== 16'hA5A5) $display("FAIL led_read_before_write got=%h exp=a5a5", g);
        else n_pass++;
        step(1'b1, 1'b1, 15'h6000, 16'hA5A5, g, e);
        step(1'b1, 1'b1, 15'h7FFF, 16'h1111, g, e);
        step(1'b0, 1'b0, 15'h7FFF, 16'h0, g, e);
        step(1'b0, 1'b1, 15'h7FFF, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0000 || led !== 16'hA5A5)
            $display("FAIL unmapped_7fff got=%h led=%h exp=0000 led=a5a5", g, led);
        else n_pass++;
        step(1'b1, 1'b1, 15'h4000, 16'h2222, g, e);
        step(1'b0, 1'b0, 15'h4000, 16'h0, g, e);
        step(1'b0, 1'b1, 15'h4000, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0000) $display("FAIL unmapped_4000 got=%h exp=0000", g);
        else n_pass++;
    endtask

    task automatic test_sw();
        logic [15:0] g, e;
        logic [7:0] v;
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            sw = v;
            for (int j = 0; j < 3; j++) begin
                step(1'b0, 1'b1, 15'h6001, 16'h0, g, e);
                n_checks++;
                if (g !== e) $display("FAIL sw_sync[%0d] got=%h exp=%h", j, g, e);
                else n_pass++;
            end
            step(1'b0, 1'b1, 15'h6001, 16'h0, g, e);
            n_checks++;
            if (g !== {8'h00, v}) $display("FAIL sw_value got=%h exp=%h", g, {8'h00, v});
            else n_pass++;
        end
    endtask

    task automatic test_btn_edge();
        logic [15:0] g, e;
        btn = 4'h0;
        step(1'b1, 1'b1, 15'h6002, 16'hFFFF, g, e);
        step(1'b1, 1'b1, 15'h6002, 16'hFFFF, g, e);
        step(1'b1, 1'b1, 15'h6002, 16'hFFFF, g, e);
        btn = 4'h4;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        btn = 4'h0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0004 || g !== e) $display("FAIL btn_pulse got=%h exp=0004 model=%h", g, e);
        else n_pass++;
        step(1'b1, 1'b1, 15'h6002, 16'h0004, g, e);
        step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0000) $display("FAIL btn_clear got=%h exp=0000", g);
        else n_pass++;
        btn = 4'h4;
        step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
        step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
        step(1'b1, 1'b1, 15'h6002, 16'h0004, g, e);
        step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0004 || g !== e) $display("FAIL btn_set_wins got=%h exp=0004 model=%h", g, e);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            btn = 4'($urandom);
            step((($urandom % 5) == 0), 1'b1, 15'h6002, 16'($urandom), g, e);
            n_checks++;
            if (g !== e) $display("FAIL btn_random[%0d] got=%h exp=%h", i, g, e);
            else n_pass++;
        end
        btn = 4'h0;
    endtask

    task automatic test_timer();
        logic [15:0] g, e;
        step(1'b1, 1'b1, 15'h6003, 16'hFFFE, g, e);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 15'h6003, 16'h0, g, e);
            n_checks++;
            if (g !== e) $display("FAIL timer_count[%0d] got=%h exp=%h", i, g, e);
            else n_pass++;
        end
        step(1'b0, 1'b1, 15'h6003, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0000) $display("FAIL timer_wrap got=%h exp=0000", g);
        else n_pass++;
        for (int i = 0; i < 2 * TD && ((cyc + 1 - tcyc) % TD) != 0; i++)
            step(1'b0, 1'b1, 15'h6003, 16'h0, g, e);
        step(1'b1, 1'b1, 15'h6003, 16'h0010, g, e);
        step(1'b0, 1'b1, 15'h6003, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0010) $display("FAIL timer_write_on_tick got=%h exp=0010", g);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            step((($urandom % 6) == 0), 1'($urandom), 15'h6003, 16'($urandom), g, e);
            n_checks++;
            if (g !== e) $display("FAIL timer_random[%0d] got=%h exp=%h", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] g, e;
        step(1'b1, 1'b1, 15'h6000, 16'h1234, g, e);
        step(1'b0, 1'b1, 15'h6000, 16'h0, g, e);
        writeM = 1'b1; en25m = 1'b1; addressM = 15'h6000; outM = 16'h7777;
        #3;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (inM !== 16'h0000 || led !== 16'h0000)
            $display("FAIL async_reset got inM=%h led=%h exp=0000", inM, led);
        else n_pass++;
        writeM = 1'b0;
        apply_reset();
        step(1'b0, 1'b1, 15'h6000, 16'h0, g, e);
        step(1'b0, 1'b1, 15'h6003, 16'h0, g, e);
        n_checks++;
        if (g !== e || led !== 16'h0000) $display("FAIL post_reset got=%h led=%h exp=%h", g, led, e);
        else n_pass++;
    endtask

`ifdef HACK_MEM_IO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [15:0] g, e;
        btn = 4'h0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
        step(1'b1, 1'b1, 15'h6002, 16'hFFFF, g, e);
        for (int p = 0; p < 3; p++) begin
            btn = 4'h1;
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
            btn = 4'h0;
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0000) $display("FAIL debounce_bounce got=%h exp=0000", g);
        else n_pass++;
        btn = 4'h1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 15'h0000, 16'h0, g, e);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 15'h6002, 16'h0, g, e);
        n_checks++;
        if (g !== 16'h0001) $display("FAIL debounce_hold got=%h exp=0001", g);
        else n_pass++;
        btn = 4'h0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_ram();
        test_led_unmapped();
        test_sw();
`ifndef HACK_MEM_IO_DEBOUNCE_EN
        test_btn_edge();
`endif
        test_timer();
        test_async_reset();
`ifdef HACK_MEM_IO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
